// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: M-stage load/store unit with an IDLE/WAIT/DONE handshake to a single-ack memory
//   pipeline side: i_req_vld/i_is_load/i_is_store/i_funct3/i_addr/i_st_data in; o_stall/o_ld_data/o_misalign/o_fault out
//   memory side:   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata/o_mem_bmask out; i_mem_ack/i_mem_rdata in
module lsu_mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic        o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q, ld_data_q, ld_data_d, wdata_d;
  logic [2:0]    f3_q;
  logic          st_q, op, legal, misal, accept, timeout, idle, in_wait;
  logic [3:0]    bmask_q, bmask_d;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  assign idle    = state_q == IDLE;
  assign in_wait = state_q == WAIT;
  assign op      = i_req_vld & (i_is_load | i_is_store);
  // stores allow 000..010; loads additionally allow 100/101
  assign legal   = i_is_store ? (~i_funct3[2] & ~&i_funct3[1:0])
                              : (~&i_funct3[1:0] & ~(i_funct3[2] & i_funct3[1]));
  assign misal   = (i_funct3[0] & i_addr[0]) | (i_funct3[1] & |i_addr[1:0]);
  assign accept  = idle & op & legal & ~misal;
  assign timeout = in_wait & ~i_mem_ack & (cnt_q == CW'(MAX_WAIT));
  assign o_fault    = (idle & op & ~legal) | timeout;
  assign o_misalign = idle & op & legal & misal;
  assign o_stall    = accept | in_wait;
  assign o_mem_req  = in_wait;
  assign o_mem_we    = st_q;
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_ld_data   = ld_data_q;
  assign bmask_d = (i_funct3[1] ? 4'b1111 : i_funct3[0] ? 4'b0011 : 4'b0001) << i_addr[1:0];
  assign wdata_d = i_funct3[1] ? i_st_data : i_funct3[0] ? {2{i_st_data[15:0]}} : {4{i_st_data[7:0]}};
  assign lane_b  = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h  = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
  // funct3[2] marks the unsigned variants
  assign ld_data_d = f3_q[1] ? i_mem_rdata
                   : f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h}
                   : {{24{~f3_q[2] & lane_b[7]}}, lane_b};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_data_q <= '0;
      f3_q      <= '0;
      st_q      <= 1'b0;
      bmask_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          addr_q  <= i_addr;
          f3_q    <= i_funct3;
          st_q    <= i_is_store;
          bmask_q <= bmask_d;
          wdata_q <= wdata_d;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (i_mem_ack) begin
            if (!st_q) ld_data_q <= ld_data_d;
            state_q <= DONE;
          end else if (timeout) begin
            if (!st_q) ld_data_q <= '0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
  logic        i_clk = 1'b0;
  logic        i_rst, i_req_vld, i_is_load, i_is_store, i_mem_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_st_data, i_mem_rdata;
  logic        o_stall, o_misalign, o_fault, o_mem_req, o_mem_we;
  logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  int n_cmp = 0, n_bad = 0;
  int stalls, fcnt, fc;
  logic [31:0] maddr, wd;
  logic [3:0]  bm;
  logic        we;
  always #5 i_clk = ~i_clk;
  lsu_mem_stage #(.MAX_WAIT(15)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .i_is_load(i_is_load),
    .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_stall(o_stall), .o_ld_data(o_ld_data), .o_misalign(o_misalign), .o_fault(o_fault),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    i_req_vld = 0; i_is_load = 0; i_is_store = 0; i_funct3 = 0; i_addr = 0;
    i_st_data = 0; i_mem_ack = 0; i_mem_rdata = 0;
  endtask
  task automatic next();
    @(posedge i_clk);
    #1;
  endtask
  // presents an op and holds it until the first non-stalled cycle after acceptance (DONE);
  // ack is raised k cycles after the accept cycle (k<0: never)
  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, d, rd,
                       input int k, output int n_st, output int n_f, output int f_at,
                       output logic [31:0] m_addr, m_wd, output logic [3:0] m_bm, output logic m_we);
    logic done;
    done = 0; n_st = 0; n_f = 0; f_at = -1; m_addr = 0; m_wd = 0; m_bm = 0; m_we = 0;
    i_req_vld = 1; i_is_load = ld; i_is_store = !ld; i_funct3 = f3; i_addr = a;
    i_st_data = d; i_mem_rdata = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      i_mem_ack = (c == k);
      @(negedge i_clk);
      if (o_stall) n_st++;
      if (o_fault) begin
        n_f++;
        if (f_at < 0) f_at = c;
      end
      if (o_mem_req) begin
        m_addr = o_mem_addr; m_wd = o_mem_wdata; m_bm = o_mem_bmask; m_we = o_mem_we;
      end
      if (c > 0 && !o_stall) done = 1;
      next();
    end
    check("op_reaches_done", 32'(done), 32'd1);
    idle_inputs();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle_inputs();
    i_rst = 1;
    next(); next();
    i_rst = 0;
    @(negedge i_clk);
    check("rst_stall", 32'(o_stall), 0);
    check("rst_req", 32'(o_mem_req), 0);
    check("rst_ld", o_ld_data, 0);
    check("rst_flags", {30'd0, o_fault, o_misalign}, 0);
    check("rst_latched", o_mem_addr | o_mem_wdata | 32'(o_mem_bmask) | 32'(o_mem_we), 0);
    next();
    do_op(1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, stalls, fcnt, fc, maddr, wd, bm, we);
    check("lw_stalls", 32'(stalls), 3);
    check("lw_addr", maddr, 32'h100);
    check("lw_we", 32'(we), 0);
    check("lw_nofault", 32'(fcnt), 0);
    @(negedge i_clk);
    check("lw_data", o_ld_data, 32'hDEADBEEF);
    next();
    do_op(1, 3'b000, 32'h103, 0, 32'h80FF1234, 1, stalls, fcnt, fc, maddr, wd, bm, we);
    check("lb_stalls", 32'(stalls), 2);
    check("lb_addr", maddr, 32'h100);
    @(negedge i_clk);
    check("lb_data", o_ld_data, 32'hFFFFFF80);
    next();
    do_op(1, 3'b100, 32'h103, 0, 32'h80FF1234, 1, stalls, fcnt, fc, maddr, wd, bm, we);
    @(negedge i_clk);
    check("lbu_data", o_ld_data, 32'h00000080);
    next();
    do_op(0, 3'b001, 32'h22, 32'h0000ABCD, 32'h11111111, 1, stalls, fcnt, fc, maddr, wd, bm, we);
    check("sh_bmask", 32'(bm), 32'hC);
    check("sh_wdata", wd, 32'hABCDABCD);
    check("sh_we", 32'(we), 1);
    check("sh_addr", maddr, 32'h20);
    @(negedge i_clk);
    check("sh_keeps_ld", o_ld_data, 32'h00000080);
    next();
    do_op(0, 3'b000, 32'h01, 32'h1234565A, 0, 1, stalls, fcnt, fc, maddr, wd, bm, we);
    check("sb_bmask", 32'(bm), 32'h2);
    check("sb_wdata", wd, 32'h5A5A5A5A);
    check("sb_addr", maddr, 32'h0);
    do_op(0, 3'b010, 32'h08, 32'hCAFEF00D, 0, 1, stalls, fcnt, fc, maddr, wd, bm, we);
    check("sw_bmask", 32'(bm), 32'hF);
    check("sw_wdata", wd, 32'hCAFEF00D);
    do_op(1, 3'b101, 32'h42, 0, 32'h12345678, 3, stalls, fcnt, fc, maddr, wd, bm, we);
    check("lhu_stalls", 32'(stalls), 4);
    @(negedge i_clk);
    check("lhu_data", o_ld_data, 32'h00001234);
    next();
    i_req_vld = 1; i_is_load = 1; i_funct3 = 3'b010; i_addr = 32'h102;
    @(negedge i_clk);
    check("mis_pulse", 32'(o_misalign), 1);
    check("mis_stall", 32'(o_stall), 0);
    check("mis_req", 32'(o_mem_req), 0);
    check("mis_nofault", 32'(o_fault), 0);
    next();
    idle_inputs();
    @(negedge i_clk);
    check("mis_clear", 32'(o_misalign), 0);
    check("mis_req_after", 32'(o_mem_req), 0);
    next();
    i_req_vld = 1; i_is_store = 1; i_funct3 = 3'b100;
    @(negedge i_clk);
    check("ill_st_fault", 32'(o_fault), 1);
    check("ill_st_stall", {30'd0, o_stall, o_mem_req}, 0);
    next();
    i_is_store = 0; i_is_load = 1; i_funct3 = 3'b011; i_addr = 32'h101;
    @(negedge i_clk);
    check("ill_mis_fault", 32'(o_fault), 1);
    check("ill_mis_nomis", 32'(o_misalign), 0);
    next();
    idle_inputs();
    @(negedge i_clk);
    check("ill_clear", 32'(o_fault), 0);
    next();
    do_op(1, 3'b001, 32'h40, 0, 32'hFFFFFFFF, -1, stalls, fcnt, fc, maddr, wd, bm, we);
    check("to_stalls", 32'(stalls), 17);
    check("to_fault_cnt", 32'(fcnt), 1);
    check("to_fault_at", 32'(fc), 16);
    @(negedge i_clk);
    check("to_ld_zero", o_ld_data, 0);
    next();
    do_op(1, 3'b001, 32'h40, 0, 32'h00008001, 16, stalls, fcnt, fc, maddr, wd, bm, we);
    check("late_ack_stalls", 32'(stalls), 17);
    check("late_ack_nofault", 32'(fcnt), 0);
    @(negedge i_clk);
    check("late_ack_data", o_ld_data, 32'hFFFF8001);
    next();
    i_req_vld = 1; i_is_load = 1; i_funct3 = 3'b010; i_addr = 32'h10;
    @(negedge i_clk);
    check("rw_accept", 32'(o_stall), 1);
    next();
    @(negedge i_clk);
    check("rw_wait_req", 32'(o_mem_req), 1);
    i_rst = 1;
    next();
    i_rst = 0;
    idle_inputs();
    i_mem_ack = 1; i_mem_rdata = 32'h12345678;
    @(negedge i_clk);
    check("rw_req_off", 32'(o_mem_req), 0);
    check("rw_stall_off", 32'(o_stall), 0);
    check("rw_ld_cleared", o_ld_data, 0);
    next();
    i_mem_ack = 0;
    @(negedge i_clk);
    check("rw_ack_ignored", o_ld_data, 0);
    check("rw_idle", {30'd0, o_mem_req, o_stall}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum number of WAIT cycles without ack before a fault.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
- Ports are listed below as name, direction, width, meaning; clock and reset come first.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous active-high reset.
REQ-003 SHALL expose the pipeline-side ports:
- i_req_vld  in  1  valid instruction in M stage.
- i_is_load  in  1  M-stage op is a load.
- i_is_store  in  1  M-stage op is a store.
- i_funct3  in  3  access size/sign code.
- i_addr  in  32  byte address (ALU result).
- i_st_data  in  32  rs2 store data.
- o_stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM stages.
- o_ld_data  out  32  aligned, extended load result, fed to the MEM/WB register.
- o_misalign  out  1  misaligned-access pulse.
- o_fault  out  1  illegal-funct3 or timeout pulse.
REQ-004 SHALL expose the memory-side ports:
- o_mem_req  out  1  request.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  32  word address, bits [1:0] = 0.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_bmask  out  4  byte enables.
- i_mem_ack  in  1  one-cycle completion.
- i_mem_rdata  in  32  read word, valid with ack.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT and DONE, plus a wait counter wide enough to count to MAX_WAIT.
REQ-006 In IDLE, an op is accepted when i_req_vld is 1, (i_is_load or i_is_store) is 1, funct3 is legal and the address is aligned.
- On acceptance, o_stall SHALL be 1 combinationally in that same cycle.
- On acceptance, SHALL latch addr, funct3, load/store, bmask and wdata, clear the counter, and go to WAIT.
REQ-007 Legal funct3 values:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other value SHALL pulse o_fault for 1 cycle, issue no request, keep o_stall at 0 and remain in IDLE.
REQ-008 Alignment: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL pulse o_misalign for 1 cycle, issue no request, keep o_stall at 0 and remain in IDLE.
- If an access is both misaligned and has illegal funct3, o_fault SHALL take priority.
REQ-009 In WAIT:
- o_mem_req=1 and o_stall=1.
- o_mem_addr, o_mem_we, o_mem_wdata and o_mem_bmask SHALL be driven from the latched values and held stable.
- The counter SHALL increment every cycle.
REQ-010 In WAIT, when i_mem_ack=1:
- For a load, o_ld_data SHALL be updated from i_mem_rdata using the latched offset and funct3.
- The FSM SHALL go to DONE.
REQ-011 Timeout: if the counter equals MAX_WAIT and i_mem_ack=0:
- o_fault SHALL pulse for 1 cycle.
- o_ld_data SHALL be set to 0 for a load.
- The FSM SHALL go to DONE.
- If ack and timeout occur in the same cycle, ack SHALL win.
REQ-012 In DONE:
- o_mem_req=0 and o_stall=0, so the pipeline advances on this edge.
- The FSM SHALL return to IDLE unconditionally and SHALL NOT re-accept the still-present op.
REQ-013 Byte-enable mask is shifted left by addr[1:0]:
- SB: 0001.
- SH: 0011.
- SW: 1111.
REQ-014 Store data placement:
- SB: wdata = {4{b}}.
- SH: wdata = {2{h}}.
- SW: wdata = data unchanged.
REQ-015 Loads select the byte or halfword lane from the latched addr[1:0].
- LB and LH sign-extend to 32 bits.
- LBU and LHU zero-extend to 32 bits.
REQ-016 o_ld_data SHALL hold its value until the next load completes or times out; stores SHALL NOT modify it.
REQ-017 o_mem_req SHALL be 0 in IDLE and DONE; i_mem_ack SHALL be ignored outside WAIT.
REQ-018 Latency: an op accepted at cycle T with ack at cycle T+k (k≥1) SHALL have DONE at T+k+1 and o_stall=0 from T+k+1.

Reset
REQ-019 While i_rst=1 at a rising edge, the following SHALL hold on the next cycle:
- state=IDLE and counter=0.
- o_ld_data=0.
- o_stall=0, o_mem_req=0, o_misalign=0 and o_fault=0.
- Latched fields SHALL be 0.
REQ-020 A reset during WAIT SHALL abandon the access: o_mem_req=0 the next cycle, and a late ack SHALL be ignored.

Verification
REQ-021 LW: addr=0x100, ack after 2 WAIT cycles with rdata=0xDEADBEEF.
- o_stall SHALL be 1 for 3 cycles.
- o_ld_data SHALL be 0xDEADBEEF.
- o_mem_addr SHALL be 0x100.
REQ-022 LB and LBU: addr=0x103, rdata=0x80FF_1234.
- LB SHALL give o_ld_data=0xFFFFFF80.
- LBU SHALL give o_ld_data=0x00000080.
REQ-023 SH: addr=0x22, st_data=0x0000ABCD.
- o_mem_bmask SHALL be 1100.
- o_mem_wdata SHALL be 0xABCDABCD.
- o_mem_we SHALL be 1 and o_mem_addr SHALL be 0x20.
REQ-024 LW at addr=0x102:
- o_misalign SHALL pulse for 1 cycle.
- o_mem_req SHALL stay 0 and o_stall SHALL stay 0.
REQ-025 LH at 0x40 with no ack and MAX_WAIT=15:
- o_fault SHALL pulse once at WAIT cycle 15.
- o_ld_data SHALL be 0.
- o_stall SHALL fall in the DONE cycle.
- A variant with ack in that same cycle SHALL load normally with no fault.
REQ-026 Assert i_rst in WAIT cycle 1, then ack 1 cycle later:
- o_mem_req SHALL be 0 and the state SHALL be IDLE.
- o_ld_data SHALL remain 0.
